// File: rtl/video_raster_gen.sv
// Runtime-programmable raster timing generator: h/v counters, syncs, blanking, active coordinates,
// positional interrupt and flash/frame toggles, with a double-buffered timing set applied at frame start.
module video_raster_gen #(
  parameter int HW      = 10,
  parameter int VW      = 10,
  parameter int FLASH_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          cfg_we,
  input  logic [HW-1:0] cfg_h_total,
  input  logic [HW-1:0] cfg_hs_beg,
  input  logic [HW-1:0] cfg_hs_end,
  input  logic [HW-1:0] cfg_ha_beg,
  input  logic [HW-1:0] cfg_ha_end,
  input  logic [VW-1:0] cfg_v_total,
  input  logic [VW-1:0] cfg_vs_beg,
  input  logic [VW-1:0] cfg_vs_end,
  input  logic [VW-1:0] cfg_va_beg,
  input  logic [VW-1:0] cfg_va_end,
  input  logic [1:0]    cfg_pol,
  input  logic [HW-1:0] int_h,
  input  logic [VW-1:0] int_v,
  input  logic          int_ack,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          int_req,
  output logic          cfg_busy,
  output logic          flash,
  output logic          frame
);

  typedef struct packed {
    logic [HW-1:0] h_total;
    logic [HW-1:0] hs_beg;
    logic [HW-1:0] hs_end;
    logic [HW-1:0] ha_beg;
    logic [HW-1:0] ha_end;
    logic [VW-1:0] v_total;
    logic [VW-1:0] vs_beg;
    logic [VW-1:0] vs_end;
    logic [VW-1:0] va_beg;
    logic [VW-1:0] va_end;
    logic [1:0]    pol;
  } timing_t;

  typedef enum logic [1:0] {UNCFG, RUN, PEND} state_t;

  state_t             r_state;
  timing_t            r_act;
  timing_t            r_pend;
  timing_t            w_cfg_in;
  logic [HW-1:0]      r_hcount;
  logic [VW-1:0]      r_vcount;
  logic               r_busy;
  logic               r_hsync, r_vsync, r_csync, r_hblank, r_vblank;
  logic [HW-1:0]      r_x;
  logic [VW-1:0]      r_y;
  logic               r_int;
  logic [FLASH_W-1:0] r_flash;
  logic               w_running;
  logic               w_line_end;
  logic               w_hs_act, w_vs_act, w_ha_act, w_va_act;
  logic               w_int_set;

  assign w_cfg_in = {cfg_h_total, cfg_hs_beg, cfg_hs_end, cfg_ha_beg, cfg_ha_end,
                     cfg_v_total, cfg_vs_beg, cfg_vs_end, cfg_va_beg, cfg_va_end, cfg_pol};

  assign w_running   = (r_state != UNCFG);
  assign w_line_end  = (r_hcount == r_act.h_total);
  assign line_start  = w_running && ce && w_line_end;
  assign frame_start = line_start && (r_vcount == r_act.v_total);

  // beg >= end yields an empty window without special casing
  assign w_hs_act = (r_hcount >= r_act.hs_beg) && (r_hcount < r_act.hs_end);
  assign w_ha_act = (r_hcount >= r_act.ha_beg) && (r_hcount < r_act.ha_end);
  assign w_vs_act = (r_vcount >= r_act.vs_beg) && (r_vcount < r_act.vs_end);
  assign w_va_act = (r_vcount >= r_act.va_beg) && (r_vcount < r_act.va_end);
  assign w_int_set = w_running && ce && (r_hcount == int_h) && (r_vcount == int_v);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= UNCFG;
      r_act    <= '0;
      r_pend   <= '0;
      r_hcount <= '0;
      r_vcount <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        UNCFG: begin
          if (cfg_we) begin
            r_act   <= w_cfg_in;
            r_state <= RUN;
          end
        end
        RUN, PEND: begin
          if (ce) begin
            if (w_line_end) begin
              r_hcount <= '0;
              r_vcount <= (r_vcount == r_act.v_total) ? '0 : r_vcount + VW'(1);
            end else begin
              r_hcount <= r_hcount + HW'(1);
            end
          end
          // A write coinciding with frame_start applies the older pending set and stays pending
          if (r_state == PEND && frame_start)
            r_act <= r_pend;
          if (cfg_we) begin
            r_pend  <= w_cfg_in;
            r_busy  <= 1'b1;
            r_state <= PEND;
          end else if (r_state == PEND && frame_start) begin
            r_busy  <= 1'b0;
            r_state <= RUN;
          end
        end
        default: r_state <= UNCFG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_csync  <= 1'b1;
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_x      <= '0;
      r_y      <= '0;
    end else if (w_running) begin
      r_hsync  <= ~(w_hs_act ^ r_act.pol[0]);
      r_vsync  <= ~(w_vs_act ^ r_act.pol[1]);
      r_csync  <= ~(w_hs_act ^ w_vs_act);
      r_hblank <= ~w_ha_act;
      r_vblank <= ~w_va_act;
      r_x      <= r_hcount - r_act.ha_beg;
      r_y      <= r_vcount - r_act.va_beg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int   <= 1'b0;
      r_flash <= '0;
    end else begin
      if (w_int_set)
        r_int <= 1'b1;
      else if (int_ack)
        r_int <= 1'b0;
      if (frame_start)
        r_flash <= r_flash + FLASH_W'(1);
    end
  end

  assign hcount   = r_hcount;
  assign vcount   = r_vcount;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign csync    = r_csync;
  assign hblank   = r_hblank;
  assign vblank   = r_vblank;
  assign de       = ~r_hblank & ~r_vblank;
  assign x        = r_x;
  assign y        = r_y;
  assign int_req  = r_int;
  assign cfg_busy = r_busy;
  assign flash    = r_flash[FLASH_W-1];
  assign frame    = r_flash[0];

endmodule
